// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - branch resolution recovery sequencer: mispredict detect, flush, fetch redirect, counters
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_stall,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic                  br_taken,
    input  logic [ADDR_WIDTH-1:0] br_next_pc,
    input  logic                  br_pred_taken,
    input  logic [ADDR_WIDTH-1:0] br_pred_target,
    output logic                  flush,
    output logic                  branch_stall,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0]            FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              flush_cnt;
    logic                    accept;
    logic                    mispredict;
    logic [ADDR_WIDTH-1:0]   actual_pc;

    // Acceptance only depends on the registered state, so br_ready has no input path.
    assign accept     = br_valid & (state == S_IDLE) & ~system_stall;
    assign actual_pc  = br_taken ? br_next_pc : (br_pc + PC_ONE);
    assign mispredict = (br_taken != br_pred_taken) |
                        (br_taken & br_pred_taken & (br_next_pc != br_pred_target));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = S_IDLE;
        br_ready       = 1'b0;
        flush          = 1'b0;
        branch_stall   = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            S_IDLE: begin
                br_ready   = 1'b1;
                state_next = (accept && mispredict) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                flush        = 1'b1;
                branch_stall = 1'b1;
                state_next   = (!system_stall && flush_cnt == 4'd0) ? S_REDIRECT : S_FLUSH;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                branch_stall   = 1'b1;
                state_next     = redirect_ready ? S_IDLE : S_REDIRECT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt   <= 4'd0;
            redirect_pc <= '0;
        end else if (accept && mispredict) begin
            flush_cnt   <= FLUSH_LAST;
            redirect_pc <= actual_pc;
        end else if (state == S_FLUSH && !system_stall && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - randomized and directed checks of branch_redirect_ctrl against a pending-redirect model
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        system_stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_next_pc = '0;
    logic        br_pred_taken = 1'b0;
    logic [31:0] br_pred_target = '0;
    logic        redirect_ready = 1'b0;

    logic        br_ready, flush, branch_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    logic        s_br_ready, s_flush, s_branch_stall, s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_branch_count, s_mispredict_count;

    int total = 0;
    int bad = 0;

    // Model: a mispredict opens a pending recovery that first burns m_left flush cycles, then waits on fetch.
    bit          m_pend;
    int          m_left;
    logic [31:0] m_rpc;
    int          m_bc, m_mc, m_bc4, m_mc4;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .system_stall(system_stall),
        .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc), .br_taken(br_taken),
        .br_next_pc(br_next_pc), .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
        .flush(flush), .branch_stall(branch_stall), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset), .system_stall(system_stall),
        .br_valid(br_valid), .br_ready(s_br_ready), .br_pc(br_pc), .br_taken(br_taken),
        .br_next_pc(br_next_pc), .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
        .flush(s_flush), .branch_stall(s_branch_stall), .redirect_valid(s_redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(s_redirect_pc),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    task automatic model_reset();
        m_pend = 0; m_left = 0; m_rpc = '0;
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
    endtask

    task automatic model_edge();
        bit mis;
        if (!m_pend) begin
            if (br_valid && !system_stall) begin
                mis = (br_taken != br_pred_taken) ||
                      (br_taken && br_pred_taken && br_next_pc != br_pred_target);
                if (m_bc < 65535) m_bc++;
                if (m_bc4 < 15) m_bc4++;
                if (mis) begin
                    if (m_mc < 65535) m_mc++;
                    if (m_mc4 < 15) m_mc4++;
                    m_pend = 1;
                    m_left = 2;
                    m_rpc  = br_taken ? br_next_pc : br_pc + 32'd1;
                end
            end
        end else if (m_left > 0) begin
            if (!system_stall) m_left--;
        end else if (redirect_ready) begin
            m_pend = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic tk, input logic [31:0] nxt,
                              input logic ptk, input logic [31:0] ptg);
        br_valid = 1'b1; br_pc = pc; br_taken = tk; br_next_pc = nxt;
        br_pred_taken = ptk; br_pred_target = ptg;
    endtask

    task automatic drain();
        br_valid = 1'b0;
        system_stall = 1'b0;
        redirect_ready = 1'b1;
        for (int i = 0; i < 20 && m_pend; i++) tick();
        tick();
        total++;
        if (br_ready !== 1'b1) begin
            bad++; $display("FAIL drain_idle br_ready=%b want 1", br_ready);
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({br_ready, flush, branch_stall, redirect_valid} !== 4'b1000 || redirect_pc !== 32'h0 ||
            branch_count !== 16'h0 || mispredict_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_state rdy/fl/st/rv=%b%b%b%b pc=%h bc=%0d mc=%0d want 1000 0 0 0",
                     br_ready, flush, branch_stall, redirect_valid, redirect_pc, branch_count, mispredict_count);
        end
    endtask

    task automatic test_correct_b2b();
        int nf = 0, nr = 0;
        for (int i = 0; i < 5; i++) begin
            set_branch(32'h40 + i, 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
            if (flush) nf++;
            if (!br_ready) nr++;
        end
        br_valid = 1'b0;
        total++;
        if (nf != 0 || nr != 0) begin
            bad++; $display("FAIL b2b_ready flush_cycles=%0d not_ready_cycles=%0d want 0 0", nf, nr);
        end
        total++;
        if (branch_count !== 16'd5 || mispredict_count !== 16'd0) begin
            bad++; $display("FAIL b2b_counts bc=%0d mc=%0d want 5 0", branch_count, mispredict_count);
        end
    endtask

    task automatic test_mispredict_not_taken();
        int nf = 0, nr = 0;
        logic [31:0] seen_pc = '0;
        redirect_ready = 1'b1;
        set_branch(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (flush) nf++;
            if (redirect_valid) begin nr++; seen_pc = redirect_pc; end
            tick();
        end
        total++;
        if (nf != 2 || nr != 1) begin
            bad++; $display("FAIL nt_seq flush_cycles=%0d redirect_cycles=%0d want 2 1", nf, nr);
        end
        total++;
        if (seen_pc !== 32'h101) begin
            bad++; $display("FAIL nt_redirect_pc got=%h want 00000101", seen_pc);
        end
        total++;
        if (mispredict_count !== 16'(m_mc) || br_ready !== 1'b1) begin
            bad++; $display("FAIL nt_after mc=%0d rdy=%b want %0d 1", mispredict_count, br_ready, m_mc);
        end
    endtask

    task automatic test_target_mismatch_hold();
        int budget = 0;
        redirect_ready = 1'b0;
        set_branch(32'h80, 1'b1, 32'h200, 1'b1, 32'h204);
        tick();
        br_valid = 1'b0;
        while (!redirect_valid && budget < 10) begin tick(); budget++; end
        total++;
        if (!redirect_valid) begin
            bad++; $display("FAIL tm_redirect_timeout rv=%b want 1", redirect_valid);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || br_ready !== 1'b0) begin
                bad++; $display("FAIL tm_hold%0d rv=%b pc=%h rdy=%b want 1 00000200 0",
                                i, redirect_valid, redirect_pc, br_ready);
            end
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        total++;
        if (br_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL tm_release rdy=%b rv=%b want 1 0", br_ready, redirect_valid);
        end
    endtask

    task automatic test_stall();
        int nf = 0;
        logic [15:0] bc_before;
        redirect_ready = 1'b1;
        set_branch(32'h10, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (flush) nf++;
            system_stall = (i < 2);
            tick();
        end
        system_stall = 1'b0;
        total++;
        if (nf != 4) begin
            bad++; $display("FAIL stall_flush_len got=%0d want 4", nf);
        end
        bc_before = branch_count;
        set_branch(32'h50, 1'b0, 32'h0, 1'b0, 32'h0);
        system_stall = 1'b1;
        repeat (3) tick();
        total++;
        if (branch_count !== bc_before || branch_count !== 16'(m_bc) || br_ready !== 1'b1) begin
            bad++; $display("FAIL stall_idle bc=%0d rdy=%b want %0d 1", branch_count, br_ready, m_bc);
        end
        br_valid = 1'b0;
        system_stall = 1'b0;
    endtask

    task automatic test_async_reset_and_wrap();
        int budget = 0;
        redirect_ready = 1'b0;
        set_branch(32'h7, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        br_valid = 1'b0;
        while (!redirect_valid && budget < 10) begin tick(); budget++; end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1 ||
            branch_count !== 16'h0 || mispredict_count !== 16'h0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL async_reset rv=%b fl=%b rdy=%b bc=%0d mc=%0d pc=%h want 0 0 1 0 0 0",
                            redirect_valid, flush, br_ready, branch_count, mispredict_count, redirect_pc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b1;
        set_branch(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 32'h1234);
        tick();
        br_valid = 1'b0;
        total++;
        if (redirect_pc !== 32'h0 || flush !== 1'b1) begin
            bad++; $display("FAIL wrap_pc pc=%h fl=%b want 00000000 1", redirect_pc, flush);
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_branch(32'h1000 + i, 1'b1, 32'h2000, 1'b0, 32'h0);
            tick();
            drain();
        end
        total++;
        if (s_branch_count !== 4'd15 || s_mispredict_count !== 4'd15) begin
            bad++; $display("FAIL sat_small bc=%0d mc=%0d want 15 15", s_branch_count, s_mispredict_count);
        end
        total++;
        if (branch_count !== 16'(m_bc) || mispredict_count !== 16'(m_mc)) begin
            bad++; $display("FAIL sat_wide bc=%0d mc=%0d want %0d %0d",
                            branch_count, mispredict_count, m_bc, m_mc);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt [4];
        bit acc;
        int errs = 0;
        tgt[0] = 32'h200; tgt[1] = 32'h204; tgt[2] = 32'h0; tgt[3] = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!br_valid && ($urandom % 3) != 0)
                set_branch(($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom),
                           tgt[$urandom % 4], 1'($urandom), tgt[$urandom % 4]);
            system_stall   = ($urandom % 5) == 0;
            redirect_ready = 1'($urandom);
            acc = br_valid && !m_pend && !system_stall;
            tick();
            if (acc) br_valid = 1'b0;
            total++;
            if (br_ready !== !m_pend || flush !== (m_pend && m_left > 0) || branch_stall !== m_pend ||
                redirect_valid !== (m_pend && m_left == 0) || redirect_pc !== m_rpc ||
                branch_count !== 16'(m_bc) || mispredict_count !== 16'(m_mc) ||
                s_branch_count !== 4'(m_bc4) || s_mispredict_count !== 4'(m_mc4)) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL rand_cyc%0d rdy/fl/st/rv=%b%b%b%b pc=%h bc=%0d mc=%0d want %b%b%b%b pc=%h bc=%0d mc=%0d",
                             cyc, br_ready, flush, branch_stall, redirect_valid, redirect_pc,
                             branch_count, mispredict_count, !m_pend, (m_pend && m_left > 0), m_pend,
                             (m_pend && m_left == 0), m_rpc, m_bc, m_mc);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_correct_b2b();
        test_mispredict_not_taken();
        test_target_mismatch_hold();
        test_stall();
        test_async_reset_and_wrap();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
